// File: rtl/map_loader.sv
// Streams one selected puzzle (easy/hard, index 0..7) cell by cell into board storage
// over a ready/valid write port, tracking hidden-cell count and out-of-range digits.
module map_loader #(
  parameter int N_MAPS  = 8,
  parameter int N_CELLS = 81,
  parameter int DIG_W   = 4,
  parameter int VIS_W   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              hard,
  input  logic [2:0]                        map_sel,
  input  logic [N_MAPS*N_CELLS*VIS_W-1:0]   visibilities_easy,
  input  logic [N_MAPS*N_CELLS*VIS_W-1:0]   visibilities_hard,
  input  logic [N_MAPS*N_CELLS*DIG_W-1:0]   maps_easy,
  input  logic [N_MAPS*N_CELLS*DIG_W-1:0]   maps_hard,
  output logic                              cell_valid,
  input  logic                              cell_ready,
  output logic [6:0]                        cell_addr,
  output logic [DIG_W-1:0]                  cell_digit,
  output logic                              cell_given,
  output logic                              busy,
  output logic                              done,
  output logic                              fmt_err,
  output logic [6:0]                        hidden_cnt
);

  localparam int MAP_W     = N_CELLS * DIG_W;
  localparam int VMAP_W    = N_CELLS * VIS_W;
  localparam int MAPS_TOT  = N_MAPS * MAP_W;
  localparam int VIS_TOT   = N_MAPS * VMAP_W;
  localparam int DPW       = $clog2(MAPS_TOT);
  localparam int VPW       = $clog2(VIS_TOT);
  localparam logic [6:0] LAST_CELL = 7'(N_CELLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             hard_q;
  logic [2:0]       sel_q;
  logic [6:0]       addr_q;
  logic [DIG_W-1:0] digit_q;
  logic             given_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             fmt_err_q;
  logic [6:0]       hidden_q;

  logic             lk_hard_s;
  logic [2:0]       lk_sel_s;
  logic [6:0]       lk_addr_s;
  logic [DPW-1:0]   dig_pos_s;
  logic [VPW-1:0]   vis_pos_s;
  logic [DIG_W-1:0] lk_digit_s;
  logic [VIS_W-1:0] lk_pair_s;
  logic             lk_given_s;

  function automatic logic digit_ok(input logic [DIG_W-1:0] d);
    return (d >= DIG_W'(1)) && (d <= DIG_W'(9));
  endfunction

  // Fetch the cell that will be presented next: cell 0 of the requested puzzle when idle,
  // otherwise the successor of the current cell in the latched puzzle.
  always_comb begin
    lk_hard_s = hard_q;
    lk_sel_s  = sel_q;
    lk_addr_s = (addr_q == LAST_CELL) ? addr_q : addr_q + 7'd1;
    if (state_q == IDLE) begin
      lk_hard_s = hard;
      lk_sel_s  = map_sel;
      lk_addr_s = 7'd0;
    end else begin
      lk_hard_s = hard_q;
    end
    dig_pos_s  = DPW'(MAPS_TOT - 1) - DPW'(lk_sel_s) * DPW'(MAP_W) - DPW'(lk_addr_s) * DPW'(DIG_W);
    vis_pos_s  = VPW'(VIS_TOT - 1) - VPW'(lk_sel_s) * VPW'(VMAP_W) - VPW'(lk_addr_s) * VPW'(VIS_W);
    lk_digit_s = lk_hard_s ? maps_hard[dig_pos_s -: DIG_W] : maps_easy[dig_pos_s -: DIG_W];
    lk_pair_s  = lk_hard_s ? visibilities_hard[vis_pos_s -: VIS_W]
                           : visibilities_easy[vis_pos_s -: VIS_W];
    lk_given_s = (lk_pair_s == {VIS_W{1'b1}});
  end

  // Load sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hard_q    <= 1'b0;
      sel_q     <= 3'd0;
      addr_q    <= 7'd0;
      digit_q   <= '0;
      given_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fmt_err_q <= 1'b0;
      hidden_q  <= 7'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            hard_q    <= hard;
            sel_q     <= map_sel;
            addr_q    <= 7'd0;
            digit_q   <= lk_digit_s;
            given_q   <= lk_given_s;
            fmt_err_q <= 1'b0;
            hidden_q  <= 7'd0;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          if (cell_ready) begin
            hidden_q  <= hidden_q + {6'd0, ~given_q};
            fmt_err_q <= fmt_err_q | ~digit_ok(digit_q);
            if (addr_q == LAST_CELL) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q  <= addr_q + 7'd1;
              digit_q <= lk_digit_s;
              given_q <= lk_given_s;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cell_valid = valid_q;
  assign cell_addr  = addr_q;
  assign cell_digit = digit_q;
  assign cell_given = given_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fmt_err    = fmt_err_q;
  assign hidden_cnt = hidden_q;

endmodule

// File: tb/tb_map_loader.sv
// Bench for map_loader: random puzzle tables, table-driven load runs checked beat by beat
// against per-cell arrays, plus reset-mid-load and restart-ignored sequences.
module tb_map_loader;

  logic          clk = 1'b0;
  logic          rst, start, hard, cell_ready;
  logic [2:0]    map_sel;
  logic [1295:0] visibilities_easy, visibilities_hard;
  logic [2591:0] maps_easy, maps_hard;
  logic          cell_valid, cell_given, busy, done, fmt_err;
  logic [6:0]    cell_addr, hidden_cnt;
  logic [3:0]    cell_digit;

  logic [3:0] dig_m [2][8][81];
  logic [1:0] vis_m [2][8][81];

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit hd;
    int sel;
    int mode;      // 0 ready high, 1 ready toggling, 2 ready random, 3 ready high + restart at 40
    int exp_done;  // expected done cycle, -1 when not checked
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  map_loader dut (
    .clk(clk), .rst(rst), .start(start), .hard(hard), .map_sel(map_sel),
    .visibilities_easy(visibilities_easy), .visibilities_hard(visibilities_hard),
    .maps_easy(maps_easy), .maps_hard(maps_hard),
    .cell_valid(cell_valid), .cell_ready(cell_ready), .cell_addr(cell_addr),
    .cell_digit(cell_digit), .cell_given(cell_given), .busy(busy), .done(done),
    .fmt_err(fmt_err), .hidden_cnt(hidden_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_load(input vec_t v);
    int  cyc, beat, hid, limit;
    bit  ferr, restarted, r;
    hid = 0;
    ferr = 1'b0;
    for (int c = 0; c < 81; c++) begin
      if (vis_m[v.hd][v.sel][c] != 2'b11) hid++;
      if (dig_m[v.hd][v.sel][c] < 4'd1 || dig_m[v.hd][v.sel][c] > 4'd9) ferr = 1'b1;
    end
    @(negedge clk);
    hard = v.hd; map_sel = 3'(v.sel); start = 1'b1; cell_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; hard = ~v.hd; map_sel = 3'($urandom_range(0, 7));
    cyc = 1; beat = 0; restarted = 1'b0; limit = 1000;
    chk("first_valid", cell_valid, 1);
    chk("fmt_err_cleared", fmt_err, 0);
    chk("hidden_cleared", hidden_cnt, 0);
    while (!done && cyc < limit) begin
      if (cell_valid && beat < 81) begin
        chk("addr", cell_addr, beat);
        chk("digit", cell_digit, dig_m[v.hd][v.sel][beat]);
        chk("given", cell_given, (vis_m[v.hd][v.sel][beat] == 2'b11) ? 1 : 0);
        chk("busy_in_load", busy, 1);
      end
      case (v.mode)
        1:       r = cyc[0];
        2:       r = 1'($urandom_range(0, 1));
        default: r = 1'b1;
      endcase
      if (v.mode == 3 && !restarted && cell_valid && cell_addr == 7'd40) begin
        start = 1'b1; map_sel = 3'd5; hard = ~v.hd; restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      cell_ready = r;
      if (cell_valid && r) beat++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("beats", beat, 81);
    if (v.exp_done >= 0) chk("done_cycle", cyc, v.exp_done);
    chk("hidden_cnt", hidden_cnt, hid);
    chk("fmt_err", fmt_err, ferr);
    chk("valid_at_done", cell_valid, 0);
    chk("busy_at_done", busy, 0);
    cell_ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("hidden_hold", hidden_cnt, hid);
    chk("fmt_err_hold", fmt_err, ferr);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hard = 1'b0; map_sel = 3'd0; cell_ready = 1'b0;
    for (int h = 0; h < 2; h++)
      for (int k = 0; k < 8; k++)
        for (int c = 0; c < 81; c++) begin
          dig_m[h][k][c] = 4'($urandom_range(1, 9));
          vis_m[h][k][c] = 2'($urandom_range(0, 3));
        end
    dig_m[0][0][0] = 4'd3; vis_m[0][0][0] = 2'b11;
    dig_m[0][0][1] = 4'd2; vis_m[0][0][1] = 2'b11;
    vis_m[0][0][4] = 2'b01;
    dig_m[1][0][0] = 4'd2; dig_m[1][0][1] = 4'd6; dig_m[1][0][2] = 4'd7; dig_m[1][0][3] = 4'd4;
    vis_m[1][0][0] = 2'b11; vis_m[1][0][1] = 2'b11; vis_m[1][0][2] = 2'b00; vis_m[1][0][3] = 2'b11;
    dig_m[0][3][50] = 4'd0;
    dig_m[1][6][10] = 4'hC;
    vis_m[1][7][80] = 2'b10;
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 81; c++) begin
        maps_easy[2591 - 324*k - 4*c -: 4]         = dig_m[0][k][c];
        maps_hard[2591 - 324*k - 4*c -: 4]         = dig_m[1][k][c];
        visibilities_easy[1295 - 162*k - 2*c -: 2] = vis_m[0][k][c];
        visibilities_hard[1295 - 162*k - 2*c -: 2] = vis_m[1][k][c];
      end

    vecs.push_back('{hd: 1'b0, sel: 0, mode: 0, exp_done: 82});
    vecs.push_back('{hd: 1'b1, sel: 0, mode: 0, exp_done: 82});
    vecs.push_back('{hd: 1'b0, sel: 1, mode: 1, exp_done: 162});
    vecs.push_back('{hd: 1'b1, sel: 7, mode: 0, exp_done: 82});
    vecs.push_back('{hd: 1'b0, sel: 3, mode: 0, exp_done: 82});
    vecs.push_back('{hd: 1'b1, sel: 6, mode: 2, exp_done: -1});
    vecs.push_back('{hd: 1'b0, sel: 4, mode: 3, exp_done: 82});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{hd: 1'($urandom_range(0, 1)), sel: $urandom_range(0, 7), mode: 2, exp_done: -1});

    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", cell_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", cell_addr, 0);
    chk("rst_hidden", hidden_cnt, 0);
    chk("rst_fmt_err", fmt_err, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_load(vecs[i]);

    // Reset in the middle of a load, then a fresh load must restart at cell 0.
    @(negedge clk);
    hard = 1'b0; map_sel = 3'd2; start = 1'b1; cell_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200 && !(cell_valid && cell_addr == 7'd30); n++) @(negedge clk);
    chk("reached_addr30", cell_addr, 30);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cell_ready = 1'b0;
    chk("midrst_valid", cell_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_addr", cell_addr, 0);
    run_load('{hd: 1'b0, sel: 2, mode: 0, exp_done: 82});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
